// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice.
//   - ALU control codes understood by the shared alu.
//   - Highest legal control code; anything above it is rejected.
//   - Arbiter state encoding.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_OR  = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_SLT = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_SGT = 4'd7;
  localparam logic [3:0] OP_XOR = 4'd8;

  localparam logic [3:0] OP_MAX = OP_XOR;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input grant logic with a round-robin pointer.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   enable         : grants are only issued while enabled (arbiter idle)
//   valid0, valid1 : requester valids
//   gnt0, gnt1     : one-hot (or zero) combinational grants
// The pointer remembers the last requester granted; on contention the
// other one wins. With FIXED_PRI set, requester 0 always wins.
module rr_arb2 #(
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic valid0,
  input  logic valid1,
  output logic gnt0,
  output logic gnt1
);

  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (enable) begin
      if (FIXED_PRI) begin
        gnt0 = valid0;
        gnt1 = valid1 & ~valid0;
      end else if (valid0 && valid1) begin
        gnt0 = last_grant_q;
        gnt1 = ~last_grant_q;
      end else begin
        gnt0 = valid0;
        gnt1 = valid1;
      end
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (gnt0) last_grant_d = 1'b0;
    if (gnt1) last_grant_d = 1'b1;
  end

  // Reset to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_grant_q <= 1'b1;
    else       last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational alu between the EX stage (requester 0) and the
// convolution engine (requester 1).
// Ports:
//   clk, reset                      : clock, asynchronous active-high reset
//   reqN_valid/ready/op/a/b         : request handshake and payload
//   rsp_valid/ready                 : response handshake
//   rsp_id/result/zero/err          : response owner, result, zero flag, bad op
//   alu_enable/control/in1/in2      : drive to the alu (zero unless issuing)
//   alu_res, alu_zero               : alu outputs, sampled only at end of ISSUE
// Flow: IDLE (accept) -> ISSUE (1 cycle, alu driven) -> HOLD (until
// rsp_ready). Illegal opcodes go IDLE -> HOLD with rsp_err set.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int              DATA_W    = 32,
  parameter int              OP_W      = 4,
  parameter logic [OP_W-1:0] MAX_OP    = OP_W'(OP_MAX),
  parameter bit              FIXED_PRI = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic              alu_enable,
  output logic [OP_W-1:0]   alu_control,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  input  logic [DATA_W-1:0] alu_res,
  input  logic              alu_zero
);

  arb_state_e        state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              id_q, id_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic              rsp_zero_q, rsp_zero_d;
  logic              rsp_err_q, rsp_err_d;

  logic              gnt0, gnt1;
  logic              accept;
  logic              acc_id;
  logic [OP_W-1:0]   acc_op;
  logic [DATA_W-1:0] acc_a, acc_b;
  logic              acc_illegal;
  logic              issuing;

  rr_arb2 #(
    .FIXED_PRI(FIXED_PRI)
  ) u_arb (
    .clk   (clk),
    .reset (reset),
    .enable(state_q == ST_IDLE),
    .valid0(req0_valid),
    .valid1(req1_valid),
    .gnt0  (gnt0),
    .gnt1  (gnt1)
  );

  assign req0_ready  = gnt0;
  assign req1_ready  = gnt1;
  assign accept      = gnt0 | gnt1;
  assign acc_id      = gnt1;
  assign acc_op      = gnt1 ? req1_op : req0_op;
  assign acc_a       = gnt1 ? req1_a  : req0_a;
  assign acc_b       = gnt1 ? req1_b  : req0_b;
  assign acc_illegal = (acc_op > MAX_OP);

  // Outside ISSUE the alu sees all-zero inputs so nothing downstream of it
  // toggles on stale operands.
  assign issuing     = (state_q == ST_ISSUE);
  assign alu_enable  = issuing;
  assign alu_control = issuing ? op_q : '0;
  assign alu_in1     = issuing ? a_q  : '0;
  assign alu_in2     = issuing ? b_q  : '0;

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_err    = rsp_err_q;

  always_comb begin
    op_d = op_q;
    a_d  = a_q;
    b_d  = b_q;
    id_d = id_q;
    if ((state_q == ST_IDLE) && accept) begin
      op_d = acc_op;
      a_d  = acc_a;
      b_d  = acc_b;
      id_d = acc_id;
    end
  end

  always_comb begin
    state_d      = state_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (acc_illegal) begin
            // Bad opcode never reaches the alu; answer immediately.
            state_d      = ST_HOLD;
            rsp_valid_d  = 1'b1;
            rsp_id_d     = acc_id;
            rsp_result_d = '0;
            rsp_zero_d   = 1'b0;
            rsp_err_d    = 1'b1;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        state_d      = ST_HOLD;
        rsp_valid_d  = 1'b1;
        rsp_id_d     = id_q;
        rsp_result_d = alu_res;
        rsp_zero_d   = alu_zero;
        rsp_err_d    = 1'b0;
      end
      ST_HOLD: begin
        if (rsp_ready) begin
          state_d      = ST_IDLE;
          rsp_valid_d  = 1'b0;
          rsp_id_d     = 1'b0;
          rsp_result_d = '0;
          rsp_zero_d   = 1'b0;
          rsp_err_d    = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  // Operation latch: only observed through the ISSUE-gated alu outputs and
  // rsp_id capture, so it needs no reset.
  always_ff @(posedge clk) begin
    op_q <= op_d;
    a_q  <= a_d;
    b_q  <= b_d;
    id_q <= id_d;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational alu between two requesters: requester 0 is the RISC-V EX stage and requester 1 is the convolution engine's pixel/kernel arithmetic.
- Accepts one operation at a time over a valid/ready handshake and grants the ALU by round-robin, or by fixed priority when configured.
- Drives the alu's operand, control and enable inputs, and captures its result and zero flag into a response register.
- Sits between the ID/EX pipeline register, the convolution controller and the alu instance.

Parameters:
- DATA_W, 32, operand and result width.
- OP_W, 4, ALU control code width.
- MAX_OP, 4'b1000, highest legal ALU control code (xor).
- FIXED_PRI, 0, 0 = round-robin; 1 = requester 0 always wins.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid / req1_valid  in  1  requester has an operation.
- req0_ready / req1_ready  out  1  operation accepted this cycle when valid & ready.
- req0_op / req1_op  in  OP_W  ALU control code.
- req0_a, req0_b / req1_a, req1_b  in  DATA_W  operands.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  1  requester that owns the response.
- rsp_result  out  DATA_W  captured ALU result.
- rsp_zero  out  1  captured zero flag.
- rsp_err  out  1  illegal opcode.
- alu_enable  out  1  to alu id_ex_enable.
- alu_control  out  OP_W  to alu id_ex_alu_control.
- alu_in1 / alu_in2  out  DATA_W  to alu in1 / in2.
- alu_res  in  DATA_W  from alu alu_result.
- alu_zero  in  1  from alu zero_flag.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: all outputs 0. State = IDLE. Round-robin pointer last_grant = 1, so requester 0 wins the first contention.
- States are IDLE, ISSUE and HOLD.
- IDLE:
  - req0_ready / req1_ready are combinational grant outputs; at most one is high.
  - Grant rule, round-robin mode: a sole valid requester is granted. On contention, the requester != last_grant is granted.
  - Grant rule, FIXED_PRI=1: requester 0 is granted whenever req0_valid is high.
  - On accept: latch op, a and b; latch id; update last_grant; go to ISSUE.
- ISSUE (exactly 1 cycle):
  - alu_enable=1; alu_control/alu_in1/alu_in2 driven from the latch registers.
  - At the clock edge, capture alu_res and alu_zero into rsp_result and rsp_zero. Set rsp_valid=1, rsp_id=latched id, rsp_err=0. Go to HOLD.
- Illegal opcode (op > MAX_OP):
  - Detected at accept. Skip ISSUE and go directly to HOLD; alu_enable stays 0.
  - Response: rsp_err=1, rsp_result=0, rsp_zero=0. The ALU's undriven (z) outputs are never sampled.
- HOLD:
  - rsp_* stable while rsp_valid & !rsp_ready.
  - On rsp_ready: clear rsp_valid and go to IDLE. The response fields clear to 0 at the same edge.
  - Both reqN_ready=0 in ISSUE and HOLD.
- Sampling rule: alu_enable=0 in IDLE and HOLD, with alu_in1/alu_in2/alu_control forced to 0. The block samples alu_res/alu_zero only at the end of ISSUE.
- Latency and throughput:
  - Accept in cycle N; ALU driven in N+1; rsp_valid visible from N+2.
  - Minimum repeat interval is 3 cycles per operation (accept, issue, hold with rsp_ready=1).
- Requesters must hold valid and payload stable until ready. The arbiter does not latch un-granted requests.
- Simultaneous events: req valid arriving in HOLD during the rsp_ready cycle is not accepted until the following IDLE cycle.
- Reset mid-operation: the latched operation and any held response are discarded, the state returns to IDLE, and no response is produced.
- Widths: the arbiter passes operands unmodified. Result width is DATA_W; no sign or shift interpretation happens here.

Decomposition:
- Shared package alu_pkg:
  - ALU control code constants: ADD=0, SUB=1, OR=2, AND=3, SLT=4, SLL=5, SRL=6, SGT=7, XOR=8, and MAX_OP.
  - State encoding IDLE/ISSUE/HOLD.
- Sub-module rr_arb2: a 2-input round-robin grant with last_grant input and FIXED_PRI. It is combinational apart from the pointer register.
- The alu is instantiated at the level above, not inside this block.

Test Plan:
- Single request: req0 op=ADD, a=5, b=7 -> alu_enable high exactly 1 cycle. In cycle N+2: rsp_valid=1, rsp_id=0, rsp_result=12, rsp_zero=0.
- Zero flag: req1 op=SUB, a=b=32'h0000_00FF -> rsp_result=0, rsp_zero=1, rsp_id=1.
- Contention, round-robin: both valid continuously with rsp_ready=1. Grants are 0,1,0,1 after reset. With FIXED_PRI=1, grants are 0,0,0.
- Backpressure: rsp_ready=0 for 5 cycles after the response appears -> rsp_* stable. Both readies stay 0 and alu_enable stays 0 throughout.
- Illegal op: req0 op=4'b1010 -> alu_enable never asserted. rsp_err=1, rsp_result=0, rsp_zero=0, with 1-cycle accept-to-rsp latency.
- Reset mid-operation: assert reset during ISSUE, asynchronously between edges -> all outputs 0 immediately. No rsp_valid after release. The next contention grants requester 0.
